// File: rtl/second_operand_stage.sv
// Registered ALU B-operand stage between ID and EX: source select, EX/MEM forwarding,
// load-use stall detection, valid/ready handshake and flush. SOP_WB_BYPASS_EN adds a WB bypass.
module second_operand_stage #(
  parameter int XLEN        = 32,
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             S,
  input  logic [REG_W-1:0]       rs2,
  input  logic [XLEN-1:0]        PB,
  input  logic [11:0]            imm12_I,
  input  logic [11:0]            imm12_S,
  input  logic [11:0]            imm12_B,
  input  logic [19:0]            imm20,
  input  logic [19:0]            imm20_J,
  input  logic [XLEN-1:0]        PC,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   mem_wr_en,
  input  logic [REG_W-1:0]       mem_rd,
  input  logic [XLEN-1:0]        mem_result,
`ifdef SOP_WB_BYPASS_EN
  input  logic                   wb_wr_en,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic [XLEN-1:0]        wb_result,
`endif
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        N,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    SRC_PB    = 3'd0,
    SRC_IMM_I = 3'd1,
    SRC_IMM_S = 3'd2,
    SRC_IMM_U = 3'd3,
    SRC_PC    = 3'd4,
    SRC_IMM_B = 3'd5,
    SRC_IMM_J = 3'd6,
    SRC_ZERO  = 3'd7
  } src_e;

  src_e src;
  assign src = src_e'(S);

  // Signed intermediates so that a width cast to XLEN performs the sign extension.
  logic signed [11:0] imm_i_s;
  logic signed [11:0] imm_s_s;
  logic signed [31:0] imm_u_s;
  logic signed [12:0] imm_b_s;
  logic signed [20:0] imm_j_s;

  assign imm_i_s = imm12_I;
  assign imm_s_s = imm12_S;
  assign imm_u_s = {imm20, 12'h000};
  assign imm_b_s = {imm12_B, 1'b0};
  assign imm_j_s = {imm20_J, 1'b0};

  logic rs2_nz;
  logic ex_fwd;
  logic mem_fwd;
  logic wb_fwd;
  logic hazard;
  logic xfer;
  logic [XLEN-1:0] pb_fwd;
  logic [XLEN-1:0] wb_val;
  logic [XLEN-1:0] sel_val;

  assign rs2_nz  = (rs2 != '0);
  assign ex_fwd  = ex_wr_en && !ex_is_load && (ex_rd == rs2) && rs2_nz;
  assign mem_fwd = mem_wr_en && (mem_rd == rs2) && rs2_nz;

`ifdef SOP_WB_BYPASS_EN
  assign wb_fwd = wb_wr_en && (wb_rd == rs2) && rs2_nz;
  assign wb_val = wb_result;
`else
  assign wb_fwd = 1'b0;
  assign wb_val = PB;
`endif

  // A load in EX cannot be forwarded yet: the consumer has to wait one cycle.
  assign hazard = in_valid && (src == SRC_PB) && ex_wr_en && ex_is_load &&
                  (ex_rd == rs2) && rs2_nz;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] n_q, n_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pb_fwd = PB;
    if (ex_fwd)       pb_fwd = ex_result;
    else if (mem_fwd) pb_fwd = mem_result;
    else if (wb_fwd)  pb_fwd = wb_val;
  end

  always_comb begin
    sel_val = '0;
    unique case (src)
      SRC_PB:    sel_val = pb_fwd;
      SRC_IMM_I: sel_val = XLEN'(imm_i_s);
      SRC_IMM_S: sel_val = XLEN'(imm_s_s);
      SRC_IMM_U: sel_val = XLEN'(imm_u_s);
      SRC_PC:    sel_val = PC;
      SRC_IMM_B: sel_val = XLEN'(imm_b_s);
      SRC_IMM_J: sel_val = XLEN'(imm_j_s);
      SRC_ZERO:  sel_val = '0;
      default:   sel_val = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    n_d         = n_q;
    stall_cnt_d = stall_cnt_q;

    // Flush squashes both the held operand and any operand accepted this cycle.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      n_d         = sel_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      n_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      n_q         <= n_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign N           = n_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_second_operand_stage.sv
// Scoreboard bench for second_operand_stage (XLEN=64, STALL_CNT_W=4); builds with or without SOP_WB_BYPASS_EN.
module tb_second_operand_stage;

  localparam int XLEN        = 64;
  localparam int REG_W       = 5;
  localparam int STALL_CNT_W = 4;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       S;
  logic [REG_W-1:0] rs2;
  logic [XLEN-1:0]  PB;
  logic [11:0]      imm12_I, imm12_S, imm12_B;
  logic [19:0]      imm20, imm20_J;
  logic [XLEN-1:0]  PC;
  logic             ex_wr_en, ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic [XLEN-1:0]  ex_result;
  logic             mem_wr_en;
  logic [REG_W-1:0] mem_rd;
  logic [XLEN-1:0]  mem_result;
`ifdef SOP_WB_BYPASS_EN
  logic             wb_wr_en;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_result;
`endif
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  N;
  logic [STALL_CNT_W-1:0] stall_count;

  second_operand_stage #(
    .XLEN(XLEN), .REG_W(REG_W), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .rs2(rs2), .PB(PB),
    .imm12_I(imm12_I), .imm12_S(imm12_S), .imm12_B(imm12_B),
    .imm20(imm20), .imm20_J(imm20_J), .PC(PC),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
`ifdef SOP_WB_BYPASS_EN
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
`endif
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .N(N), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] exp_q[$];
  bit              m_valid;
  int              m_stalls;

  task automatic check(input string name, input bit ok,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: the operand the instruction asks for, in plain arithmetic.
  function automatic logic [XLEN-1:0] ref_value();
    logic [31:0] u;
    logic [12:0] b;
    logic [20:0] j;
    u = {imm20, 12'h000};
    b = {imm12_B, 1'b0};
    j = {imm20_J, 1'b0};
    case (S)
      3'd0: begin
        if (rs2 != 0 && ex_wr_en && !ex_is_load && ex_rd == rs2) return ex_result;
        if (rs2 != 0 && mem_wr_en && mem_rd == rs2) return mem_result;
`ifdef SOP_WB_BYPASS_EN
        if (rs2 != 0 && wb_wr_en && wb_rd == rs2) return wb_result;
`endif
        return PB;
      end
      3'd1: return longint'($signed(imm12_I));
      3'd2: return longint'($signed(imm12_S));
      3'd3: return longint'($signed(u));
      3'd4: return PC;
      3'd5: return longint'($signed(b));
      3'd6: return longint'($signed(j));
      default: return '0;
    endcase
  endfunction

  // Evaluated just before each rising edge: compare live outputs, then advance the model.
  task automatic model_edge();
    bit hz, rdy, xfer;
    int exp_cnt;
    hz  = in_valid && S == 3'd0 && ex_wr_en && ex_is_load && ex_rd == rs2 && rs2 != 0;
    rdy = (!m_valid || out_ready) && !hz;
    exp_cnt = (m_stalls > STALL_MAX) ? STALL_MAX : m_stalls;
    check("in_ready", in_ready === rdy, in_ready, rdy);
    check("out_valid", out_valid === m_valid, out_valid, m_valid);
    check("stall_count", stall_count === exp_cnt[STALL_CNT_W-1:0], stall_count, exp_cnt);
    if (m_valid && !out_ready && exp_q.size() > 0)
      check("n_hold", N === exp_q[0], N, exp_q[0]);

    xfer = in_valid && rdy;
    if (hz) m_stalls++;
    if (flush) begin
      if (m_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 1'b0;
    end else if (xfer) begin
      exp_q.push_back(ref_value());
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: every consumed operand is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1'b0, N, '0);
      else begin
        logic [XLEN-1:0] e;
        e = exp_q.pop_front();
        check("n_out", N === e, N, e);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #4;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 1; flush = 0; S = 0; rs2 = 0; PB = 0; PC = 0;
    imm12_I = 0; imm12_S = 0; imm12_B = 0; imm20 = 0; imm20_J = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_wr_en = 0; mem_rd = 0; mem_result = 0;
`ifdef SOP_WB_BYPASS_EN
    wb_wr_en = 0; wb_rd = 0; wb_result = 0;
`endif
  endtask

  task automatic random_inputs();
    int r;
    r = $urandom_range(0, 11);
    S          = (r > 7) ? 3'd0 : r[2:0];
    in_valid   = $urandom_range(0, 3) != 0;
    out_ready  = $urandom_range(0, 3) != 0;
    flush      = $urandom_range(0, 15) == 0;
    rs2        = REG_W'($urandom_range(0, 7));
    PB         = {$urandom, $urandom};
    PC         = {$urandom, $urandom};
    imm12_I    = 12'($urandom); imm12_S = 12'($urandom); imm12_B = 12'($urandom);
    imm20      = 20'($urandom); imm20_J = 20'($urandom);
    ex_wr_en   = $urandom_range(0, 1) != 0;
    ex_is_load = $urandom_range(0, 3) == 0;
    ex_rd      = REG_W'($urandom_range(0, 7));
    ex_result  = {$urandom, $urandom};
    mem_wr_en  = $urandom_range(0, 1) != 0;
    mem_rd     = REG_W'($urandom_range(0, 7));
    mem_result = {$urandom, $urandom};
`ifdef SOP_WB_BYPASS_EN
    wb_wr_en   = $urandom_range(0, 1) != 0;
    wb_rd      = REG_W'($urandom_range(0, 7));
    wb_result  = {$urandom, $urandom};
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid  = 1'b0;
    m_stalls = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid === 1'b0, out_valid, 0);
    check("reset_n", N === '0, N, 0);
    check("reset_stall", stall_count === '0, stall_count, 0);
    reset = 1'b0;

    // Immediate sign extension to 64 bits.
    in_valid = 1; S = 3'd1; imm12_I = 12'hFFF;
    step();
    check("imm_i_sext", N === 64'hFFFF_FFFF_FFFF_FFFF, N, 64'hFFFF_FFFF_FFFF_FFFF);
    S = 3'd6; imm20_J = 20'h00001;
    step();
    check("imm_j", N === 64'd2, N, 64'd2);
    S = 3'd3; imm20 = 20'h80000;
    step();
    check("imm_u_sext", N === 64'hFFFF_FFFF_8000_0000, N, 64'hFFFF_FFFF_8000_0000);

    // Forwarding priority.
    S = 3'd0; rs2 = 5; PB = 64'h11;
    ex_wr_en = 1; ex_rd = 5; ex_result = 64'h22;
    mem_wr_en = 1; mem_rd = 5; mem_result = 64'h33;
    step();
    check("fwd_ex", N === 64'h22, N, 64'h22);
    ex_wr_en = 0;
    step();
    check("fwd_mem", N === 64'h33, N, 64'h33);
    rs2 = 0; ex_wr_en = 1; ex_rd = 0; mem_rd = 0;
    step();
    check("fwd_x0", N === 64'h11, N, 64'h11);

    // Load-use stall, then saturation of the counter.
    mem_wr_en = 0; rs2 = 7; ex_wr_en = 1; ex_is_load = 1; ex_rd = 7;
    repeat (3) step();
    check("stall_cnt3", stall_count === 4'd3, stall_count, 3);
    check("stall_bubble", out_valid === 1'b0, out_valid, 0);
    repeat (20) step();
    check("stall_sat", stall_count === 4'd15, stall_count, 15);
    ex_is_load = 0; ex_wr_en = 0; PB = 64'h77;
    step();
    check("after_stall", N === 64'h77, N, 64'h77);

    // Backpressure: held operand must not change.
    S = 3'd4; PC = 64'h1234_5678_9ABC_DEF0;
    step();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0]; S = 3'd1; imm12_I = 12'($urandom);
      step();
      check("bp_hold", N === 64'h1234_5678_9ABC_DEF0, N, 64'h1234_5678_9ABC_DEF0);
    end
    out_ready = 1; in_valid = 1; S = 3'd2; imm12_S = 12'h800;
    step();
    check("bp_release", N === 64'hFFFF_FFFF_FFFF_F800, N, 64'hFFFF_FFFF_FFFF_F800);

    // Flush dominates a simultaneous transfer.
    flush = 1; S = 3'd7;
    step();
    check("flush_valid", out_valid === 1'b0, out_valid, 0);
    flush = 0;

`ifdef SOP_WB_BYPASS_EN
    S = 3'd0; rs2 = 9; wb_wr_en = 1; wb_rd = 9; wb_result = 64'h44;
    ex_wr_en = 0; mem_wr_en = 0;
    step();
    check("fwd_wb", N === 64'h44, N, 64'h44);
    wb_wr_en = 0;
`endif

    // Asynchronous reset while an operand is held.
    in_valid = 1; S = 3'd4; PC = 64'hABCD;
    step();
    out_ready = 0;
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid === 1'b0, out_valid, 0);
    check("async_rst_n", N === '0, N, 0);
    check("async_rst_stall", stall_count === '0, stall_count, 0);
    model_reset();
    #1;
    reset = 1'b0;
    idle_inputs();
    step();

    for (int c = 0; c < 1500; c++) begin
      random_inputs();
      step();
    end

    idle_inputs();
    repeat (3) step();
    check("queue_drained", exp_q.size() == 0, XLEN'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/second_operand_stage.md
Name: second_operand_stage

Overview:
- Registered, parametrised successor to the combinational second-operand selector for the RISC-V PPU.
- Sits between ID and EX and drives the ALU B operand (N) into the ID/EX pipeline register.
- Adds over the combinational version: XLEN generalisation, B/J immediates, EX/MEM forwarding on the PB path, load-use stall detection, valid/ready handshake, flush, and a saturating stall counter.

Parameters:
- XLEN, 32: datapath width; must be >= 32; every immediate sign-extends to XLEN.
- REG_W, 5: register index width.
- STALL_CNT_W, 16: width of the stall_count counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  ID presents a valid operand request.
- in_ready  out  1  stage accepts the request this cycle.
- S  in  3  source select (encoding in Behaviour).
- rs2  in  REG_W  source register index for the PB path.
- PB  in  XLEN  register-file read data for rs2.
- imm12_I  in  12  I-type immediate.
- imm12_S  in  12  S-type immediate.
- imm12_B  in  12  B-type immediate bits [12:1].
- imm20  in  20  U-type immediate.
- imm20_J  in  20  J-type immediate bits [20:1].
- PC  in  XLEN  PC of the instruction.
- ex_wr_en  in  1  EX stage writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_W  EX destination register.
- ex_result  in  XLEN  EX result.
- mem_wr_en  in  1  MEM stage writes a register.
- mem_rd  in  REG_W  MEM destination register.
- mem_result  in  XLEN  MEM result.
- flush  in  1  squash the registered operand.
- out_valid  out  1  N is valid.
- out_ready  in  1  EX accepts N.
- N  out  XLEN  registered second operand.
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Source select S:
  - 0: forwarded PB.
  - 1: sext(imm12_I).
  - 2: sext(imm12_S).
  - 3: {imm20, 12'b0}, sign-extended from bit 31 when XLEN > 32.
  - 4: PC.
  - 5: sext({imm12_B, 1'b0}).
  - 6: sext({imm20_J, 1'b0}).
  - 7: zero.
- Forwarding, applied only when S == 0:
  - Match EX when ex_wr_en, ex_rd == rs2, rs2 != 0 and !ex_is_load; MEM match is the same test on mem_wr_en/mem_rd.
  - Priority: EX, then MEM, then PB.
  - rs2 == 0 always yields PB (x0 is never forwarded).
- Load-use hazard: S == 0, in_valid, ex_wr_en, ex_is_load, ex_rd == rs2, rs2 != 0.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard.
  - A transfer occurs when in_valid & in_ready.
  - On a transfer: N <= selected value; out_valid <= 1 on the next edge. Latency is 1 cycle.
  - When out_valid & !out_ready, N and out_valid hold stable.
  - When out_ready and no transfer: out_valid <= 0; N holds.
- Hazard cycle: no capture. If out_ready (or !out_valid), out_valid <= 0, inserting a bubble. stall_count increments by 1 and saturates at all-ones (no wrap).
- flush: synchronous. out_valid <= 0 on the next edge; dominates any simultaneous transfer. stall_count is unaffected.
- Reset (async, any time, including mid-stall): out_valid = 0, N = 0, stall_count = 0. in_ready is combinational and therefore follows its equation, becoming 1 while out_valid = 0 and no hazard.

Optional Feature:
- Macro: SOP_WB_BYPASS_EN.
- Defined: adds ports wb_wr_en (1), wb_rd (REG_W) and wb_result (XLEN) as a third forwarding source, lowest priority after MEM. Same rs2 != 0 rule.
- Undefined: these ports do not exist; PB is used when there is no EX/MEM match. Write-before-read is then assumed to be handled by the register file.

Test Plan:
- Reset asserted mid-transfer -> out_valid=0, N=0, stall_count=0 asynchronously, without waiting for a clock edge.
- S=1, imm12_I=12'hFFF, XLEN=64 -> N=64'hFFFF_FFFF_FFFF_FFFF one cycle after the transfer; S=6, imm20_J=20'h00001 -> N=2.
- S=0, rs2=5, PB=0x11, ex_wr_en=1/ex_rd=5/ex_result=0x22, mem_wr_en=1/mem_rd=5/mem_result=0x33 -> N=0x22; drop ex_wr_en -> N=0x33; set rs2=0 -> N=PB.
- S=0, rs2=7, ex_is_load=1/ex_wr_en=1/ex_rd=7 for 3 cycles -> in_ready=0 for those cycles, one bubble (out_valid=0), stall_count=3. With STALL_CNT_W=2, 5 stall cycles -> stall_count=3 (saturated).
- out_ready=0 with out_valid=1 while in_valid toggles with new data -> N unchanged, in_ready=0; raise out_ready -> next operand captured.
- flush and a transfer in the same cycle -> out_valid=0 next cycle. With SOP_WB_BYPASS_EN defined, wb_rd=rs2=9, wb_result=0x44, no EX/MEM match -> N=0x44.
